// File: rtl/ahb_uvc_pkg.sv
// Shared AHB types: transfer/burst encodings, arbiter states and a
// burst-length lookup used by the arbiter.
package ahb_uvc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      NONSEQ = 2'd2,
      SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      SINGLE = 3'd0,
      INCR   = 3'd1,
      WRAP4  = 3'd2,
      INCR4  = 3'd3,
      WRAP8  = 3'd4,
      INCR8  = 3'd5,
      WRAP16 = 3'd6,
      INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [1:0] {
      ST_ARB    = 2'd0,
      ST_BURST  = 2'd1,
      ST_LOCKED = 2'd2
   } arb_st_e;

   // Beats in a burst; 0 marks an unbounded INCR.
   function automatic logic [4:0] burst_len(hburst_e b);
      logic [4:0] n;
      n = 5'd1;
      unique case (b)
         SINGLE:         n = 5'd1;
         INCR:           n = 5'd0;
         WRAP4, INCR4:   n = 5'd4;
         WRAP8, INCR8:   n = 5'd8;
         WRAP16, INCR16: n = 5'd16;
         default:        n = 5'd1;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/ahb_arbiter_if.sv
// Arbitration bundle between AHB masters and the arbiter.
// master: drives requests/transfer info; slave: returns grant/owner.
interface ahb_arbiter_if
   import ahb_uvc_pkg::*;
#(
   parameter int NUM_MST  = 4,
   parameter int MST_ID_W = 2
);

   logic [NUM_MST-1:0]  hbusreq;
   logic [NUM_MST-1:0]  hlock;
   htrans_e             htrans;
   hburst_e             hburst;
   logic                hready;
   logic [NUM_MST-1:0]  hgrant;
   logic [MST_ID_W-1:0] hmaster;
   logic                hmastlock;

   modport master (
      output hbusreq, hlock, htrans, hburst, hready,
      input  hgrant, hmaster, hmastlock
   );

   modport slave (
      input  hbusreq, hlock, htrans, hburst, hready,
      output hgrant, hmaster, hmastlock
   );

endinterface

// File: rtl/ahb_rr_picker.sv
// Combinational round-robin picker: first requester after ptr.
// Ports: req, ptr in; gnt (one-hot), vld out.
module ahb_rr_picker #(
   parameter int N = 4,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] gnt,
   output logic         vld
);

   logic [W-1:0] j;

   // Offsets 1..N so ptr itself is searched last.
   always_comb begin
      gnt = '0;
      vld = 1'b0;
      j   = '0;
      for (int i = 1; i <= N; i++) begin
         j = W'((int'(ptr) + i) % N);
         if (!vld && req[j]) begin
            gnt[j] = 1'b1;
            vld    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/ahb_arbiter.sv
// AHB bus arbiter: round-robin with burst hold and locked transfers.
// Ports: hclk, hresetn; bus (slave modport) carries req/grant signals.
module ahb_arbiter
   import ahb_uvc_pkg::*;
#(
   parameter int NUM_MST     = 4,
   parameter int MST_ID_W    = 2,
   parameter int DEFAULT_MST = 0
) (
   input  logic          hclk,
   input  logic          hresetn,
   ahb_arbiter_if.slave  bus
);

   localparam logic [NUM_MST-1:0] DEF_GNT =
      NUM_MST'(1) << DEFAULT_MST;
   localparam logic [MST_ID_W-1:0] DEF_IDX =
      MST_ID_W'(DEFAULT_MST);

   arb_st_e             st_q, st_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [MST_ID_W-1:0] ptr_q, ptr_d;
   logic [NUM_MST-1:0]  gnt_q, gnt_d;
   logic [MST_ID_W-1:0] mst_q;
   logic                mlk_q;

   logic [MST_ID_W-1:0] gidx;
   logic [MST_ID_W-1:0] rr_idx;
   logic [NUM_MST-1:0]  rr_gnt;
   logic                rr_vld;
   logic [4:0]          blen;
   logic                fixed;
   logic                arb_pt;

   ahb_rr_picker #(
      .N (NUM_MST),
      .W (MST_ID_W)
   ) u_rr (
      .req (bus.hbusreq),
      .ptr (ptr_q),
      .gnt (rr_gnt),
      .vld (rr_vld)
   );

   always_comb begin
      gidx   = '0;
      rr_idx = '0;
      for (int i = 0; i < NUM_MST; i++) begin
         if (gnt_q[i])  gidx   = MST_ID_W'(i);
         if (rr_gnt[i]) rr_idx = MST_ID_W'(i);
      end
   end

   assign blen  = burst_len(bus.hburst);
   assign fixed = (blen > 5'd1);

   // Owner for lock decisions is the currently granted master.
   always_comb begin
      st_d   = st_q;
      cnt_d  = cnt_q;
      ptr_d  = ptr_q;
      gnt_d  = gnt_q;
      arb_pt = 1'b0;
      if (bus.hready) begin
         unique case (st_q)
            ST_ARB: begin
               if (bus.htrans == NONSEQ && fixed) begin
                  st_d  = ST_BURST;
                  cnt_d = 4'(blen - 5'd1);
               end else if (bus.htrans != BUSY) begin
                  arb_pt = 1'b1;
               end
            end
            ST_BURST: begin
               unique case (bus.htrans)
                  SEQ: begin
                     cnt_d = cnt_q - 4'd1;
                     if (cnt_q == 4'd1) begin
                        st_d   = ST_ARB;
                        arb_pt = 1'b1;
                     end
                  end
                  IDLE: begin
                     st_d   = ST_ARB;
                     arb_pt = 1'b1;
                  end
                  NONSEQ: st_d = ST_ARB;
                  default: ;
               endcase
            end
            ST_LOCKED: arb_pt = (bus.htrans != BUSY);
            default:   st_d = ST_ARB;
         endcase
         if (arb_pt) begin
            if (bus.hlock[gidx] && bus.hbusreq[gidx]) begin
               st_d = ST_LOCKED;
            end else begin
               st_d  = ST_ARB;
               gnt_d = rr_vld ? rr_gnt : DEF_GNT;
               ptr_d = rr_vld ? rr_idx : DEF_IDX;
            end
         end
      end
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         st_q  <= ST_ARB;
         cnt_q <= '0;
         ptr_q <= DEF_IDX;
         gnt_q <= DEF_GNT;
         mst_q <= DEF_IDX;
         mlk_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         cnt_q <= cnt_d;
         ptr_q <= ptr_d;
         gnt_q <= gnt_d;
         if (bus.hready) begin
            mst_q <= gidx;
            mlk_q <= bus.hlock[gidx];
         end
      end
   end

   assign bus.hgrant    = gnt_q;
   assign bus.hmaster   = mst_q;
   assign bus.hmastlock = mlk_q;

endmodule

// File: tb/tb_ahb_arbiter.sv
// Bench for ahb_arbiter: directed scenarios plus random traffic,
// compared against a behavioural bus-ownership model.
module tb_ahb_arbiter;
   import ahb_uvc_pkg::*;

   localparam int N = 4;

   logic hclk = 1'b0;
   logic hresetn = 1'b0;

   ahb_arbiter_if #(.NUM_MST(N), .MST_ID_W(2)) bus ();

   ahb_arbiter #(
      .NUM_MST     (N),
      .MST_ID_W    (2),
      .DEFAULT_MST (0)
   ) dut (
      .hclk    (hclk),
      .hresetn (hresetn),
      .bus     (bus)
   );

   always #5 hclk = ~hclk;

   int n_chk = 0;
   int n_pass = 0;

   // Model: granted master, current owner, beats left, lock held.
   int m_gnt, m_mst, m_left;
   bit m_mlk, m_lock;

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic chk_model(string tag);
      chk({tag, ".gnt"}, 32'(bus.hgrant), 32'(1 << m_gnt));
      chk({tag, ".mst"}, 32'(bus.hmaster), 32'(m_mst));
      chk({tag, ".mlk"}, 32'(bus.hmastlock), 32'(m_mlk));
   endtask

   function automatic int beats_of(hburst_e b);
      case (b)
         WRAP4, INCR4:   return 4;
         WRAP8, INCR8:   return 8;
         WRAP16, INCR16: return 16;
         default:        return 1;
      endcase
   endfunction

   task automatic model_reset();
      m_gnt  = 0;
      m_mst  = 0;
      m_mlk  = 0;
      m_left = 0;
      m_lock = 0;
   endtask

   task automatic step(logic [3:0] req, logic [3:0] lck, htrans_e tr,
                       hburst_e bu, logic rdy, string tag);
      int n_gnt, n_mst, n_left;
      bit n_mlk, n_lock, arb, found;
      int j;
      bus.hbusreq = req;
      bus.hlock   = lck;
      bus.htrans  = tr;
      bus.hburst  = bu;
      bus.hready  = rdy;
      n_gnt  = m_gnt;
      n_mst  = m_mst;
      n_mlk  = m_mlk;
      n_left = m_left;
      n_lock = m_lock;
      arb    = 0;
      if (rdy) begin
         n_mst = m_gnt;
         n_mlk = lck[m_gnt];
         if (m_lock) begin
            arb = (tr != BUSY);
         end else if (m_left > 0) begin
            if (tr == SEQ) begin
               n_left = m_left - 1;
               arb = (n_left == 0);
            end else if (tr == IDLE) begin
               n_left = 0;
               arb = 1;
            end else if (tr == NONSEQ) begin
               n_left = 0;
            end
         end else if (tr == NONSEQ && beats_of(bu) > 1) begin
            n_left = beats_of(bu) - 1;
         end else begin
            arb = (tr != BUSY);
         end
         if (arb) begin
            if (lck[m_gnt] && req[m_gnt]) begin
               n_lock = 1;
            end else begin
               n_lock = 0;
               n_gnt  = 0;
               found  = 0;
               for (int k = 1; k <= N; k++) begin
                  j = (m_gnt + k) % N;
                  if (!found && req[j]) begin
                     n_gnt = j;
                     found = 1;
                  end
               end
            end
         end
      end
      @(posedge hclk);
      #1;
      m_gnt  = n_gnt;
      m_mst  = n_mst;
      m_mlk  = n_mlk;
      m_left = n_left;
      m_lock = n_lock;
      chk_model(tag);
   endtask

   task automatic do_reset();
      hresetn = 1'b0;
      #2;
      model_reset();
      chk_model("rst_async");
      @(posedge hclk);
      #1;
      hresetn = 1'b1;
      chk_model("rst_rel");
   endtask

   logic [3:0] fair_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
   logic [3:0] rq, lk;

   initial begin
      bus.hbusreq = '0;
      bus.hlock   = '0;
      bus.htrans  = IDLE;
      bus.hburst  = SINGLE;
      bus.hready  = 1'b1;
      model_reset();
      #12;
      do_reset();
      chk("rst_gnt", 32'(bus.hgrant), 32'h1);
      chk("rst_mst", 32'(bus.hmaster), 32'h0);
      chk("rst_mlk", 32'(bus.hmastlock), 32'h0);

      for (int i = 0; i < 4; i++) begin
         step(4'b1111, 4'b0, NONSEQ, SINGLE, 1'b1, "fair");
         chk("fair_seq", 32'(bus.hgrant), 32'(fair_exp[i]));
      end

      step(4'b0100, 4'b0, NONSEQ, SINGLE, 1'b1, "to_m2");
      step(4'b1111, 4'b0, NONSEQ, INCR8, 1'b1, "b8_start");
      chk("burst_hold", 32'(bus.hgrant), 32'h4);
      for (int i = 0; i < 7; i++) begin
         step(4'b1111, 4'b0, SEQ, INCR8, 1'b1, "b8_seq");
         chk(i < 6 ? "burst_hold" : "burst_end",
             32'(bus.hgrant), i < 6 ? 32'h4 : 32'h8);
      end

      step(4'b1111, 4'b0, NONSEQ, INCR4, 1'b1, "b4_start");
      for (int i = 0; i < 3; i++)
         step(4'b1111, 4'b0, SEQ, INCR4, 1'b0, "b4_wait");
      step(4'b1111, 4'b0, BUSY, INCR4, 1'b1, "b4_busy");
      chk("busy_hold", 32'(bus.hgrant), 32'h8);
      step(4'b1111, 4'b0, SEQ, INCR4, 1'b1, "b4_seq");
      step(4'b1111, 4'b0, SEQ, INCR4, 1'b1, "b4_seq");
      chk("b4_hold", 32'(bus.hgrant), 32'h8);
      step(4'b1111, 4'b0, SEQ, INCR4, 1'b1, "b4_last");
      chk("b4_end", 32'(bus.hgrant), 32'h1);

      step(4'b1010, 4'b0, NONSEQ, SINGLE, 1'b1, "to_m1");
      for (int i = 0; i < 3; i++) begin
         step(4'b1010, 4'b0010, NONSEQ, SINGLE, 1'b1, "lock");
         chk("lock_gnt", 32'(bus.hgrant), 32'h2);
         chk("lock_mlk", 32'(bus.hmastlock), 32'h1);
      end
      step(4'b1010, 4'b0, NONSEQ, SINGLE, 1'b1, "unlock");
      chk("unlock_gnt", 32'(bus.hgrant), 32'h8);

      step(4'b1001, 4'b0, NONSEQ, WRAP16, 1'b1, "w16_start");
      step(4'b1001, 4'b0, IDLE, WRAP16, 1'b1, "w16_idle");
      chk("early_term", 32'(bus.hgrant), 32'h1);

      step(4'b0001, 4'b0, NONSEQ, INCR16, 1'b1, "b16_start");
      step(4'b0001, 4'b0, SEQ, INCR16, 1'b1, "b16_seq");
      do_reset();
      step(4'b0100, 4'b0, NONSEQ, SINGLE, 1'b1, "post_rst");
      chk("post_rst_gnt", 32'(bus.hgrant), 32'h4);

      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            rq = 4'($urandom);
            lk = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            step(rq, lk, htrans_e'($urandom_range(0, 3)),
                 hburst_e'($urandom_range(0, 7)),
                 ($urandom_range(0, 4) != 0), "rand");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
